i2c_status_reg: RTL and testbench

// - Consumes the 13-bit next_status vector produced by the I2C status logic.
// - Presents it to the APB slave as a readable status register.
// - Holds error bits sticky until software clears them.
// - Counts FIFO overflow/underflow events and drives a maskable level interrupt.
// - Sits between the I2C status logic and the APB register file.

---
 rtl/i2c_status_reg.sv | 114 +++++++++++
 tb/tb_i2c_status_reg.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_status_reg.sv
// ============================================================================
// Module   : i2c_status_reg
// Purpose  : I2C status register with sticky error bits, saturating error
//            counters and a maskable level interrupt for the APB register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_status_reg #(
  parameter logic [12:0] STICKY_MASK   = 13'h1200,
  parameter bit          CLEAR_ON_READ = 1'b1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [12:0]      next_status,
  input  logic             status_rd,
  input  logic             status_w1c,
  input  logic [12:0]      w1c_data,
  input  logic             ien_we,
  input  logic [12:0]      ien_wdata,
  input  logic             cnt_clr,
  output logic [12:0]      status_reg,
  output logic [12:0]      status_rdata,
  output logic [12:0]      ien,
  output logic [CNT_W-1:0] rx_ovf_cnt,
  output logic [CNT_W-1:0] tx_unf_cnt,
  output logic             irq
);

  localparam logic [12:0]      c_rst_status = 13'h0480;
  localparam logic [CNT_W-1:0] c_cnt_max    = '1;
  localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);
  localparam int unsigned      c_rx_ovf_bit = 9;
  localparam int unsigned      c_tx_unf_bit = 12;

  logic [12:0]      status_q, status_d;
  logic [12:0]      status_rdata_q, status_rdata_d;
  logic [12:0]      rd_snap_q, rd_snap_d;
  logic             rd_clr_pend_q, rd_clr_pend_d;
  logic [12:0]      ien_q, ien_d;
  logic [CNT_W-1:0] rx_ovf_cnt_q, rx_ovf_cnt_d;
  logic [CNT_W-1:0] tx_unf_cnt_q, tx_unf_cnt_d;
  logic             irq_q, irq_d;
  logic [12:0]      sticky_clr;

  always_comb begin
    // Read-clear only touches bits captured in the snapshot, so an event
    // that lands after the read is preserved.
    sticky_clr = ({13{status_w1c}} & w1c_data)
               | ({13{CLEAR_ON_READ & rd_clr_pend_q}} & rd_snap_q);

    status_d = (next_status & ~STICKY_MASK)
             | (STICKY_MASK & (next_status | (status_q & ~sticky_clr)));

    status_rdata_d = status_rdata_q;
    rd_snap_d      = rd_snap_q;
    if (status_rd) begin
      status_rdata_d = status_q;
      rd_snap_d      = status_q & STICKY_MASK;
    end
    rd_clr_pend_d = status_rd;

    ien_d = ien_we ? ien_wdata : ien_q;

    rx_ovf_cnt_d = rx_ovf_cnt_q;
    if (cnt_clr) begin
      rx_ovf_cnt_d = '0;
    end else if (next_status[c_rx_ovf_bit] && (rx_ovf_cnt_q != c_cnt_max)) begin
      rx_ovf_cnt_d = rx_ovf_cnt_q + c_cnt_one;
    end

    tx_unf_cnt_d = tx_unf_cnt_q;
    if (cnt_clr) begin
      tx_unf_cnt_d = '0;
    end else if (next_status[c_tx_unf_bit] && (tx_unf_cnt_q != c_cnt_max)) begin
      tx_unf_cnt_d = tx_unf_cnt_q + c_cnt_one;
    end

    irq_d = |(status_q & ien_q);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      status_q       <= c_rst_status;
      status_rdata_q <= '0;
      rd_snap_q      <= '0;
      rd_clr_pend_q  <= 1'b0;
      ien_q          <= '0;
      rx_ovf_cnt_q   <= '0;
      tx_unf_cnt_q   <= '0;
      irq_q          <= 1'b0;
    end else begin
      status_q       <= status_d;
      status_rdata_q <= status_rdata_d;
      rd_snap_q      <= rd_snap_d;
      rd_clr_pend_q  <= rd_clr_pend_d;
      ien_q          <= ien_d;
      rx_ovf_cnt_q   <= rx_ovf_cnt_d;
      tx_unf_cnt_q   <= tx_unf_cnt_d;
      irq_q          <= irq_d;
    end
  end

  assign status_reg   = status_q;
  assign status_rdata = status_rdata_q;
  assign ien          = ien_q;
  assign rx_ovf_cnt   = rx_ovf_cnt_q;
  assign tx_unf_cnt   = tx_unf_cnt_q;
  assign irq          = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_i2c_status_reg.sv
// ============================================================================
// Module   : tb_i2c_status_reg
// Purpose  : Directed, table-driven self-checking bench for i2c_status_reg.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_status_reg;

  localparam int unsigned CNT_W = 8;
  localparam logic [12:0] IDLE  = 13'h0480;

  logic             clk;
  logic             n_rst;
  logic [12:0]      next_status;
  logic             status_rd;
  logic             status_w1c;
  logic [12:0]      w1c_data;
  logic             ien_we;
  logic [12:0]      ien_wdata;
  logic             cnt_clr;
  logic [12:0]      status_reg;
  logic [12:0]      status_rdata;
  logic [12:0]      ien;
  logic [CNT_W-1:0] rx_ovf_cnt;
  logic [CNT_W-1:0] tx_unf_cnt;
  logic             irq;

  int total;
  int bad;

  i2c_status_reg #(
    .STICKY_MASK  (13'h1200),
    .CLEAR_ON_READ(1'b1),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .next_status (next_status),
    .status_rd   (status_rd),
    .status_w1c  (status_w1c),
    .w1c_data    (w1c_data),
    .ien_we      (ien_we),
    .ien_wdata   (ien_wdata),
    .cnt_clr     (cnt_clr),
    .status_reg  (status_reg),
    .status_rdata(status_rdata),
    .ien         (ien),
    .rx_ovf_cnt  (rx_ovf_cnt),
    .tx_unf_cnt  (tx_unf_cnt),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic [12:0] ns;
    logic        rd;
    logic        w1c;
    logic [12:0] wd;
    logic        iwe;
    logic [12:0] iwd;
    logic        cclr;
    logic [12:0] e_st;
    logic [12:0] e_rdata;
    logic [12:0] e_ien;
    logic        e_irq;
    logic [7:0]  e_rx;
    logic [7:0]  e_tx;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic rst_n, input logic [12:0] ns, input logic rd,
                     input logic w1c, input logic [12:0] wd, input logic iwe,
                     input logic [12:0] iwd, input logic cclr, input logic [12:0] e_st,
                     input logic [12:0] e_rdata, input logic [12:0] e_ien,
                     input logic e_irq, input logic [7:0] e_rx, input logic [7:0] e_tx);
    vec_t v;
    v.rst_n = rst_n; v.ns = ns; v.rd = rd; v.w1c = w1c; v.wd = wd;
    v.iwe = iwe; v.iwd = iwd; v.cclr = cclr; v.e_st = e_st; v.e_rdata = e_rdata;
    v.e_ien = e_ien; v.e_irq = e_irq; v.e_rx = e_rx; v.e_tx = e_tx;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    n_rst       = v.rst_n;
    next_status = v.ns;
    status_rd   = v.rd;
    status_w1c  = v.w1c;
    w1c_data    = v.wd;
    ien_we      = v.iwe;
    ien_wdata   = v.iwd;
    cnt_clr     = v.cclr;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    drive(v);
    check("status_reg", idx, 32'(status_reg), 32'(v.e_st));
    check("status_rdata", idx, 32'(status_rdata), 32'(v.e_rdata));
    check("ien", idx, 32'(ien), 32'(v.e_ien));
    check("irq", idx, 32'(irq), 32'(v.e_irq));
    check("rx_ovf_cnt", idx, 32'(rx_ovf_cnt), 32'(v.e_rx));
    check("tx_unf_cnt", idx, 32'(tx_unf_cnt), 32'(v.e_tx));
  endtask

  initial begin
    vec_t v;
    total = 0;
    bad   = 0;
    n_rst = 1'b0; next_status = IDLE; status_rd = 1'b0; status_w1c = 1'b0;
    w1c_data = '0; ien_we = 1'b0; ien_wdata = '0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);

    //   rst ns        rd w1c wd       iwe iwd      cclr st       rdata    ien      irq rx tx
    add(0, IDLE,     0, 0, 13'h0, 0, 13'h0,   0, 13'h0480, 13'h0000, 13'h0000, 0, 0, 0);
    add(1, IDLE,     0, 0, 13'h0, 0, 13'h0,   0, 13'h0480, 13'h0000, 13'h0000, 0, 0, 0);
    add(1, 13'h0680, 0, 0, 13'h0, 0, 13'h0,   0, 13'h0680, 13'h0000, 13'h0000, 0, 1, 0);
    add(1, IDLE,     0, 0, 13'h0, 0, 13'h0,   0, 13'h0680, 13'h0000, 13'h0000, 0, 1, 0);
    add(1, IDLE,     1, 0, 13'h0, 0, 13'h0,   0, 13'h0680, 13'h0680, 13'h0000, 0, 1, 0);
    add(1, IDLE,     0, 0, 13'h0, 0, 13'h0,   0, 13'h0480, 13'h0680, 13'h0000, 0, 1, 0);
    add(1, 13'h0680, 0, 0, 13'h0, 0, 13'h0,   0, 13'h0680, 13'h0680, 13'h0000, 0, 2, 0);
    add(1, IDLE,     1, 0, 13'h0, 0, 13'h0,   0, 13'h0680, 13'h0680, 13'h0000, 0, 2, 0);
    add(1, 13'h0680, 0, 0, 13'h0, 0, 13'h0,   0, 13'h0680, 13'h0680, 13'h0000, 0, 3, 0);
    add(1, IDLE,     0, 0, 13'h0, 0, 13'h0,   0, 13'h0680, 13'h0680, 13'h0000, 0, 3, 0);
    add(1, 13'h1480, 0, 0, 13'h0, 0, 13'h0,   0, 13'h1680, 13'h0680, 13'h0000, 0, 3, 1);
    add(1, IDLE,     0, 1, 13'h1000, 0, 13'h0, 0, 13'h0680, 13'h0680, 13'h0000, 0, 3, 1);
    add(1, 13'h0580, 0, 1, 13'h0100, 0, 13'h0, 0, 13'h0780, 13'h0680, 13'h0000, 0, 3, 1);
    add(1, IDLE,     0, 1, 13'h0200, 0, 13'h0, 0, 13'h0480, 13'h0680, 13'h0000, 0, 3, 1);
    add(1, IDLE,     0, 0, 13'h0, 1, 13'h0200, 0, 13'h0480, 13'h0680, 13'h0200, 0, 3, 1);
    add(1, 13'h0680, 0, 0, 13'h0, 0, 13'h0,   0, 13'h0680, 13'h0680, 13'h0200, 0, 4, 1);
    add(1, IDLE,     0, 0, 13'h0, 0, 13'h0,   0, 13'h0680, 13'h0680, 13'h0200, 1, 4, 1);
    add(1, IDLE,     0, 1, 13'h0200, 0, 13'h0, 0, 13'h0480, 13'h0680, 13'h0200, 1, 4, 1);
    add(1, IDLE,     0, 0, 13'h0, 0, 13'h0,   0, 13'h0480, 13'h0680, 13'h0200, 0, 4, 1);
    add(1, 13'h1680, 0, 0, 13'h0, 0, 13'h0,   1, 13'h1680, 13'h0680, 13'h0200, 0, 0, 0);
    add(1, IDLE,     0, 0, 13'h0, 1, 13'h0000, 0, 13'h1680, 13'h0680, 13'h0000, 1, 0, 0);
    add(1, IDLE,     0, 0, 13'h0, 0, 13'h0,   0, 13'h1680, 13'h0680, 13'h0000, 0, 0, 0);
    add(1, IDLE,     1, 0, 13'h0, 0, 13'h0,   0, 13'h1680, 13'h1680, 13'h0000, 0, 0, 0);
    add(1, IDLE,     0, 1, 13'h0200, 0, 13'h0, 0, 13'h0480, 13'h1680, 13'h0000, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], i);
    end

    // tx_underflow held long enough to saturate the counter
    v = vecs[1];
    v.ns = 13'h1480;
    for (int i = 0; i < 300; i++) begin
      drive(v);
      if (i == 254) check("tx_unf_cnt_at_255", 1000, 32'(tx_unf_cnt), 32'd255);
    end
    check("tx_unf_cnt_saturated", 1001, 32'(tx_unf_cnt), 32'd255);
    check("rx_ovf_cnt_idle", 1001, 32'(rx_ovf_cnt), 32'd0);
    check("status_sat", 1001, 32'(status_reg), 32'h1480);

    v.cclr = 1'b1;
    drive(v);
    check("tx_unf_cnt_clr_wins", 1002, 32'(tx_unf_cnt), 32'd0);
    v.cclr = 1'b0;
    drive(v);
    check("tx_unf_cnt_after_clr", 1003, 32'(tx_unf_cnt), 32'd1);

    // Reset in the middle of activity dominates every other input
    v.rst_n = 1'b0; v.ns = 13'h1680; v.rd = 1'b1; v.w1c = 1'b1; v.wd = 13'h1fff;
    v.iwe = 1'b1; v.iwd = 13'h1fff; v.cclr = 1'b0;
    v.e_st = 13'h0480; v.e_rdata = 13'h0; v.e_ien = 13'h0; v.e_irq = 1'b0;
    v.e_rx = 8'd0; v.e_tx = 8'd0;
    run_vec(v, 1004);

    // Back-to-back reads: each read's clear only drops bits it captured
    vecs.delete();
    add(1, 13'h0680, 0, 0, 13'h0, 0, 13'h0, 0, 13'h0680, 13'h0000, 13'h0000, 0, 1, 0);
    add(1, 13'h1480, 1, 0, 13'h0, 0, 13'h0, 0, 13'h1680, 13'h0680, 13'h0000, 0, 1, 1);
    add(1, IDLE,     1, 0, 13'h0, 0, 13'h0, 0, 13'h1480, 13'h1680, 13'h0000, 0, 1, 1);
    add(1, IDLE,     0, 0, 13'h0, 0, 13'h0, 0, 13'h0480, 13'h1680, 13'h0000, 0, 1, 1);
    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], 2000 + i);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
